// File: rtl/mipsfpga_ahb_spi_rx.sv
// mipsfpga_ahb_spi_rx
//
// SPI slave receiver (mode 0, MSB first, 8-bit frames).
// The SPI pins are oversampled on HCLK and bytes are collected into a small FIFO.
// The CPU drains the FIFO through the GPIO AHB register decoder.
// This is the receive-side companion of the LCD SPI transmitter.
//
// The SPI clock must be no faster than HCLK/8.
//
// Optional build macro MIPSFPGA_SPI_RX_ECHO_EN:
//   When defined, the last received byte is echoed back on spi_sdo.
//   When undefined, spi_sdo is tied low and no tx logic is built.
//
// Ports:
//   HCLK, HRESETn  system clock and asynchronous active-low reset
//   spi_sck        SPI clock from the master (asynchronous)
//   spi_cs_n       chip select, active-low (asynchronous)
//   spi_sdi        MOSI (asynchronous)
//   spi_sdo        MISO (echo data, or 0)
//   rd_en          one-cycle pop strobe from the register decoder
//   rd_data        FIFO head byte, 8'h00 when empty
//   rx_empty       FIFO empty
//   rx_full        FIFO full
//   rx_count       bytes held, 0..FIFO_DEPTH
//   rx_ovf         sticky overflow flag
//   ovf_clr        one-cycle clear strobe for rx_ovf
//
// Frame FSM:
//   state    | meaning
//   ST_IDLE  | cs_n high; sck edges are ignored
//   ST_SHIFT | cs_n low; shifting bits, pushing a byte every 8 sck rises

module mipsfpga_ahb_spi_rx #(
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = 3
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              spi_sck,
    input  logic              spi_cs_n,
    input  logic              spi_sdi,
    output logic              spi_sdo,
    input  logic              rd_en,
    output logic [7:0]        rd_data,
    output logic              rx_empty,
    output logic              rx_full,
    output logic [ADDR_W:0]   rx_count,
    output logic              rx_ovf,
    input  logic              ovf_clr
);

    typedef enum logic {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} state_t;

    // ------------------------------------------------------------------
    // Input synchronisers.
    // Stage [0] is the metastability catcher.
    // Stages [1]/[2] of sck and cs_n form the edge detector.
    // sdi is used from stage [1], which keeps it aligned with the detected sck edge.
    // cs_n resets high so that leaving reset with cs_n high does not fake an edge.
    // ------------------------------------------------------------------
    logic [2:0] sck_sync_q, sck_sync_d;
    logic [2:0] cs_sync_q,  cs_sync_d;
    logic [1:0] sdi_sync_q, sdi_sync_d;

    always_comb begin
        sck_sync_d = {sck_sync_q[1:0], spi_sck};
        cs_sync_d  = {cs_sync_q[1:0],  spi_cs_n};
        sdi_sync_d = {sdi_sync_q[0],   spi_sdi};
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sck_sync_q <= 3'b000;
            cs_sync_q  <= 3'b111;
            sdi_sync_q <= 2'b00;
        end else begin
            sck_sync_q <= sck_sync_d;
            cs_sync_q  <= cs_sync_d;
            sdi_sync_q <= sdi_sync_d;
        end
    end

    logic sck_rise;
    logic cs_fall;
    logic cs_rise;
    logic sdi_s;

    assign sck_rise = sck_sync_q[1] & ~sck_sync_q[2];
    assign cs_fall  = ~cs_sync_q[1] &  cs_sync_q[2];
    assign cs_rise  =  cs_sync_q[1] & ~cs_sync_q[2];
    assign sdi_s    = sdi_sync_q[1];

    // ------------------------------------------------------------------
    // Frame FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    state_t state_q, state_d;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (cs_fall) state_d = ST_SHIFT;
            ST_SHIFT: if (cs_rise) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       shift_en;
    logic       cnt_clr;
    logic       byte_done;

    // A cs_n rise takes priority over a coincident sck rise.
    // The frame is over, so that edge must not count.
    always_comb begin
        shift_en = 1'b0;
        cnt_clr  = 1'b0;
        case (state_q)
            ST_IDLE:  cnt_clr  = cs_fall;
            ST_SHIFT: begin
                cnt_clr  = cs_rise;
                shift_en = sck_rise & ~cs_rise;
            end
            default:  cnt_clr  = 1'b1;
        endcase
        byte_done = shift_en && (bit_cnt_q == 3'd7);
    end

    // ------------------------------------------------------------------
    // Shift register and bit counter.
    // The 8th bit is merged combinationally into the pushed byte.
    // This makes the byte visible one HCLK edge after its sck rise is detected.
    // ------------------------------------------------------------------
    logic [7:0] shreg_q, shreg_d;
    logic [7:0] push_byte;

    assign push_byte = {shreg_q[6:0], sdi_s};

    always_comb begin
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        if (cnt_clr) begin
            bit_cnt_d = 3'd0;
        end else if (shift_en) begin
            shreg_d   = push_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;   // wraps 7 -> 0 on byte completion
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            shreg_q   <= 8'h00;
            bit_cnt_q <= 3'd0;
        end else begin
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Receive FIFO
    // ------------------------------------------------------------------
    logic [7:0]        mem_q [FIFO_DEPTH];
    logic [7:0]        mem_d [FIFO_DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q,  count_d;
    logic              ovf_q,    ovf_d;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop_ok;
    logic              push_ok;

    assign fifo_full  = (count_q == (ADDR_W+1)'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);

    // When full, a push is only accepted if a pop frees the head slot in the same cycle.
    // The write then lands in the slot being vacated.
    assign pop_ok  = rd_en & ~fifo_empty;
    assign push_ok = byte_done & (~fifo_full | pop_ok);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_byte;
            wr_ptr_d        = wr_ptr_q + ADDR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (ADDR_W+1)'(1);
            2'b01:   count_d = count_q - (ADDR_W+1)'(1);
            default: count_d = count_q;
        endcase
        // A new overflow beats a coincident clear.
        ovf_d = (ovf_q & ~ovf_clr) | (byte_done & fifo_full & ~pop_ok);
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 8'h00;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    assign rd_data  = fifo_empty ? 8'h00 : mem_q[rd_ptr_q];
    assign rx_empty = fifo_empty;
    assign rx_full  = fifo_full;
    assign rx_count = count_q;
    assign rx_ovf   = ovf_q;

    // ------------------------------------------------------------------
    // Optional echo path
    // ------------------------------------------------------------------
`ifdef MIPSFPGA_SPI_RX_ECHO_EN
    logic [7:0] tx_q,   tx_d;
    logic [7:0] last_q, last_d;
    logic       sck_fall;

    assign sck_fall = ~sck_sync_q[1] & sck_sync_q[2];

    // The tx register shifts on sck falls, except on the fall that ends a byte.
    // That fall is the one with bit_cnt == 0.
    // By then the register has just been reloaded, and its MSB must stay on the line for the master's next rise.
    always_comb begin
        tx_d   = tx_q;
        last_d = last_q;
        if ((state_q == ST_IDLE) && cs_fall) begin
            tx_d = last_q;
        end else if (byte_done) begin
            tx_d   = push_byte;
            last_d = push_byte;
        end else if ((state_q == ST_SHIFT) && !cs_rise && sck_fall && (bit_cnt_q != 3'd0)) begin
            tx_d = {tx_q[6:0], 1'b0};
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            tx_q   <= 8'h00;
            last_q <= 8'h00;
        end else begin
            tx_q   <= tx_d;
            last_q <= last_d;
        end
    end

    assign spi_sdo = (state_q == ST_SHIFT) ? tx_q[7] : 1'b0;
`else
    assign spi_sdo = 1'b0;
`endif

endmodule

// File: tb/tb_mipsfpga_ahb_spi_rx.sv
module tb_mipsfpga_ahb_spi_rx;

    logic       HCLK     = 1'b0;
    logic       HRESETn  = 1'b0;
    logic       spi_sck  = 1'b0;
    logic       spi_cs_n = 1'b1;
    logic       spi_sdi  = 1'b0;
    logic       rd_en    = 1'b0;
    logic       ovf_clr  = 1'b0;
    logic       spi_sdo;
    logic [7:0] rd_data;
    logic       rx_empty;
    logic       rx_full;
    logic [3:0] rx_count;
    logic       rx_ovf;

    mipsfpga_ahb_spi_rx #(.FIFO_DEPTH(8), .ADDR_W(3)) dut (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .spi_sck  (spi_sck),
        .spi_cs_n (spi_cs_n),
        .spi_sdi  (spi_sdi),
        .spi_sdo  (spi_sdo),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .rx_empty (rx_empty),
        .rx_full  (rx_full),
        .rx_count (rx_count),
        .rx_ovf   (rx_ovf),
        .ovf_clr  (ovf_clr)
    );

    always #5 HCLK = ~HCLK;

    int         n_pass  = 0;
    int         n_total = 0;
    logic [7:0] exp_q[$];
    logic       sdo_seen_high = 1'b0;
    logic [7:0] mon_exp;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Scoreboard monitor: every accepted pop is compared with the oldest expected byte.
    always @(negedge HCLK) begin
        if (HRESETn && rd_en && !rx_empty) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL pop_unexpected: got 0x%0h, expected no data", rd_data);
            end else begin
                mon_exp = exp_q.pop_front();
                check("pop_data", int'(rd_data), int'(mon_exp));
            end
        end
        if (spi_sdo) sdo_seen_high = 1'b1;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    // Half an SCK period at SCK = HCLK/8.
    task automatic half();
        repeat (4) @(negedge HCLK);
    endtask

    task automatic cs_low();
        spi_cs_n = 1'b0;
        half();
    endtask

    task automatic cs_high();
        half();
        spi_cs_n = 1'b1;
        repeat (6) @(negedge HCLK);
    endtask

    // Sends nbits of b, MSB first, and samples MISO on each rising SCK edge.
    // With pop_last set, rd_en is raised so that it coincides with the push of the final bit.
    // That push happens at the third HCLK rise after SCK goes high.
    task automatic send_byte(input logic [7:0] b, input int nbits, input bit pop_last,
                             output logic [7:0] miso);
        logic [7:0] bv;
        bv   = b;
        miso = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            spi_sdi = bv[7-i];
            half();
            spi_sck = 1'b1;
            miso    = {miso[6:0], spi_sdo};
            if (pop_last && (i == nbits - 1)) begin
                @(posedge HCLK);
                @(posedge HCLK);
                #1 rd_en = 1'b1;
                @(posedge HCLK);
                #1 rd_en = 1'b0;
                repeat (2) @(negedge HCLK);
            end else begin
                half();
            end
            spi_sck = 1'b0;
        end
    endtask

    task automatic pop();
        @(posedge HCLK);
        #1 rd_en = 1'b1;
        @(posedge HCLK);
        #1 rd_en = 1'b0;
        @(negedge HCLK);
    endtask

    task automatic do_reset();
        @(negedge HCLK);
        HRESETn = 1'b0;
        repeat (3) @(negedge HCLK);
        HRESETn = 1'b1;
        repeat (2) @(negedge HCLK);
    endtask

    logic [7:0] m1, m2;
    logic [7:0] exp_m2;

    initial begin
        do_reset();
        check("rst_empty", int'(rx_empty), 1);
        check("rst_full",  int'(rx_full),  0);
        check("rst_count", int'(rx_count), 0);
        check("rst_ovf",   int'(rx_ovf),   0);
        check("rst_data",  int'(rd_data),  0);
        check("rst_sdo",   int'(spi_sdo),  0);

        // Single byte
        cs_low();
        send_byte(8'hA5, 8, 1'b0, m1);
        exp_q.push_back(8'hA5);
        cs_high();
        check("one_count", int'(rx_count), 1);
        check("one_empty", int'(rx_empty), 0);
        check("one_data",  int'(rd_data),  8'hA5);
        pop();
        check("one_empty_after", int'(rx_empty), 1);
        check("one_data_after",  int'(rd_data),  0);

        // Multi-byte frame
        cs_low();
        send_byte(8'h12, 8, 1'b0, m1); exp_q.push_back(8'h12);
        send_byte(8'h34, 8, 1'b0, m1); exp_q.push_back(8'h34);
        send_byte(8'h56, 8, 1'b0, m1); exp_q.push_back(8'h56);
        cs_high();
        check("multi_count", int'(rx_count), 3);
        repeat (3) pop();
        check("multi_empty", int'(rx_empty), 1);

        // Overflow: nine bytes into eight slots, the ninth is dropped
        cs_low();
        for (int i = 1; i <= 9; i++) begin
            send_byte(8'(8'h20 + i), 8, 1'b0, m1);
            if (i <= 8) exp_q.push_back(8'(8'h20 + i));
        end
        cs_high();
        check("ovf_full",  int'(rx_full),  1);
        check("ovf_flag",  int'(rx_ovf),   1);
        check("ovf_count", int'(rx_count), 8);
        repeat (8) pop();
        check("ovf_empty",  int'(rx_empty), 1);
        check("ovf_sticky", int'(rx_ovf),   1);
        @(posedge HCLK);
        #1 ovf_clr = 1'b1;
        @(posedge HCLK);
        #1 ovf_clr = 1'b0;
        @(negedge HCLK);
        check("ovf_cleared", int'(rx_ovf), 0);

        // Partial byte is discarded
        cs_low();
        send_byte(8'hFF, 5, 1'b0, m1);
        cs_high();
        check("partial_count", int'(rx_count), 0);
        cs_low();
        send_byte(8'h3C, 8, 1'b0, m1);
        exp_q.push_back(8'h3C);
        cs_high();
        check("partial_next_count", int'(rx_count), 1);
        check("partial_next_data",  int'(rd_data),  8'h3C);
        pop();

        // Push and pop in the same cycle while full
        cs_low();
        for (int i = 1; i <= 8; i++) begin
            send_byte(8'(8'h40 + i), 8, 1'b0, m1);
            exp_q.push_back(8'(8'h40 + i));
        end
        send_byte(8'h49, 8, 1'b1, m1);
        exp_q.push_back(8'h49);
        cs_high();
        check("simul_count", int'(rx_count), 8);
        check("simul_full",  int'(rx_full),  1);
        check("simul_ovf",   int'(rx_ovf),   0);
        repeat (8) pop();
        check("simul_empty", int'(rx_empty), 1);

        // Echo path: byte N-1 comes back while byte N is sent
        do_reset();
        sdo_seen_high = 1'b0;
        cs_low();
        send_byte(8'h81, 8, 1'b0, m1); exp_q.push_back(8'h81);
        send_byte(8'h7E, 8, 1'b0, m2); exp_q.push_back(8'h7E);
        cs_high();
`ifdef MIPSFPGA_SPI_RX_ECHO_EN
        exp_m2 = 8'h81;
`else
        exp_m2 = 8'h00;
        check("sdo_stays_low", int'(sdo_seen_high), 0);
`endif
        check("echo_first",  int'(m1), 0);
        check("echo_second", int'(m2), int'(exp_m2));
        check("echo_count",  int'(rx_count), 2);
        repeat (2) pop();

        check("scoreboard_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
